mole_spawner: RTL

Game-level mole scheduler sitting directly upstream of the per-mole rise/lower FSMs. It paces spawn opportunities from a slow tick and chooses a pseudo-random idle mole via a 16-bit LFSR. It then drives that mole's one-hot go line and holds it until the mole acknowledges by leaving its hiding state. It also counts spawns and ends the round after a fixed number of spawns.

---
 rtl/mole_spawner_pkg.sv | 33 +++
 rtl/mole_spawner_lfsr16.sv | 20 ++
 rtl/mole_spawner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mole_spawner_pkg.sv
// Shared types and constants for the mole spawner: FSM states, mole count,
// LFSR tap mask and small arithmetic helpers.
package mole_spawner_pkg;

    localparam int unsigned NUM_MOLES = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned IVL_W     = 4;
    localparam int unsigned TMO_W     = 8;

    // x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PICK  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One Fibonacci step: shift left, XOR of taps enters bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // Saturating increment for the display counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with the seed on reset.
module lfsr16
    import mole_spawner_pkg::*;
(
    input  logic              clock,
    input  logic              Mreset_wait,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    // Advance one step every clock
    always_ff @(posedge clock or posedge Mreset_wait) begin
        if (Mreset_wait) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Game-level mole scheduler: paces spawn attempts from tick, picks an idle
// mole starting at a pseudo-random index, holds its go line until the mole
// leaves hiding (or times out), and ends the round after ROUNDS spawns.
// Optional build macro MOLE_SPAWN_SPEEDUP_EN shortens the tick interval by
// one after every 8th acknowledged spawn (floor 1).
module mole_spawner
    import mole_spawner_pkg::*;
#(
    parameter int unsigned       SPAWN_INTERVAL = 4,
    parameter int unsigned       ROUNDS         = 30,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned       ACK_TIMEOUT    = 255
) (
    input  logic                 clock,
    input  logic                 Mreset_wait,
    input  logic                 start,
    input  logic                 tick,
    input  logic [NUM_MOLES-1:0] hiding,
    output logic [NUM_MOLES-1:0] control,
    output logic [CNT_W-1:0]     spawn_count,
    output logic [CNT_W-1:0]     miss_count,
    output logic                 game_over
);

    logic [LFSR_W-1:0]    lfsr_q;
    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     probe_q;
    logic [IVL_W-1:0]     ivl_cnt_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [NUM_MOLES-1:0] control_q;
    logic [CNT_W-1:0]     spawn_q;
    logic [CNT_W-1:0]     miss_q;
    logic                 game_over_q;

    logic [CNT_W-1:0]     spawn_d;
    logic                 ack_c;
    logic [IVL_W-1:0]     interval_c;
    logic                 unused_lfsr;

    lfsr16 u_lfsr (
        .clock       (clock),
        .Mreset_wait (Mreset_wait),
        .seed        (LFSR_SEED),
        .q           (lfsr_q)
    );

    // Only the low bits select a mole; the rest just keep the sequence long
    assign unused_lfsr = ^lfsr_q[LFSR_W-1:IDX_W];

    // Acknowledge: the launched mole has left its hiding state
    assign ack_c   = ~hiding[idx_q];
    assign spawn_d = sat_inc(spawn_q);

`ifdef MOLE_SPAWN_SPEEDUP_EN
    logic [IVL_W-1:0] interval_q;

    // Shrink the interval after every 8th acknowledged spawn, restore on game start
    always_ff @(posedge clock or posedge Mreset_wait) begin
        if (Mreset_wait) begin
            interval_q <= IVL_W'(SPAWN_INTERVAL);
        end else if (start && state_q == ST_IDLE) begin
            interval_q <= IVL_W'(SPAWN_INTERVAL);
        end else if (start && state_q == ST_ISSUE && ack_c &&
                     spawn_d != spawn_q && spawn_d[2:0] == 3'd0 &&
                     interval_q > IVL_W'(1)) begin
            interval_q <= interval_q - IVL_W'(1);
        end
    end

    assign interval_c = interval_q;
`else
    assign interval_c = IVL_W'(SPAWN_INTERVAL);
`endif

    // Spawn scheduler FSM with registered outputs
    always_ff @(posedge clock or posedge Mreset_wait) begin
        if (Mreset_wait) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            probe_q     <= '0;
            ivl_cnt_q   <= '0;
            tmo_q       <= '0;
            control_q   <= '0;
            spawn_q     <= '0;
            miss_q      <= '0;
            game_over_q <= 1'b0;
        end else if (!start) begin
            // Counters stay visible until the next game starts
            state_q     <= ST_IDLE;
            control_q   <= '0;
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    control_q   <= '0;
                    spawn_q     <= '0;
                    miss_q      <= '0;
                    game_over_q <= 1'b0;
                    ivl_cnt_q   <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (ivl_cnt_q == interval_c - IVL_W'(1)) begin
                            ivl_cnt_q <= '0;
                            idx_q     <= lfsr_q[IDX_W-1:0];
                            probe_q   <= '0;
                            state_q   <= ST_PICK;
                        end else begin
                            ivl_cnt_q <= ivl_cnt_q + IVL_W'(1);
                        end
                    end
                end
                ST_PICK: begin
                    if (hiding[idx_q]) begin
                        control_q <= NUM_MOLES'(1) << idx_q;
                        tmo_q     <= '0;
                        state_q   <= ST_ISSUE;
                    end else if (probe_q == IDX_W'(NUM_MOLES - 1)) begin
                        miss_q  <= sat_inc(miss_q);
                        state_q <= ST_WAIT;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        probe_q <= probe_q + IDX_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (ack_c) begin
                        control_q <= '0;
                        spawn_q   <= spawn_d;
                        if (spawn_d == CNT_W'(ROUNDS)) begin
                            game_over_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        control_q <= '0;
                        miss_q    <= sat_inc(miss_q);
                        state_q   <= ST_WAIT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    control_q   <= '0;
                    game_over_q <= 1'b1;
                end
                default: begin
                    control_q <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign control     = control_q;
    assign spawn_count = spawn_q;
    assign miss_count  = miss_q;
    assign game_over   = game_over_q;

endmodule
